// File: rtl/cache_pkg.sv
// Shared widths, address-field struct and width helpers for the direct-mapped tag lookup.
package cache_pkg;

    localparam int unsigned CACHE_ADDR_W      = 32;
    localparam int unsigned CACHE_NUM_LINES   = 64;
    localparam int unsigned CACHE_BLOCK_BYTES = 16;

    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

    function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                               input int unsigned num_lines,
                                               input int unsigned block_bytes);
        return addr_w - log2_ceil(num_lines) - log2_ceil(block_bytes);
    endfunction

    localparam int unsigned DEF_INDEX_W  = log2_ceil(CACHE_NUM_LINES);
    localparam int unsigned DEF_OFFSET_W = log2_ceil(CACHE_BLOCK_BYTES);
    localparam int unsigned DEF_TAG_W    = calc_tag_w(CACHE_ADDR_W, CACHE_NUM_LINES, CACHE_BLOCK_BYTES);

    // Field layout of an address in the default geometry, MSB first.
    typedef struct packed {
        logic [DEF_TAG_W-1:0]    tag;
        logic [DEF_INDEX_W-1:0]  index;
        logic [DEF_OFFSET_W-1:0] offset;
    } addr_fields_t;

endpackage

// File: rtl/cache_tag_array.sv
// Valid bits and tag store for the direct-mapped cache; combinational read, single allocate write.
module cache_tag_array #(
    parameter int unsigned NUM_LINES = 64,
    parameter int unsigned INDEX_W   = 6,
    parameter int unsigned TAG_W     = 22
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag_mem [NUM_LINES];

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag_mem[i_rd_index];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tags need no reset: a line is only compared once its valid bit is set.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag_mem[i_wr_index] <= i_wr_tag;
        end
    end

endmodule

// File: rtl/cache_main.sv
// Direct-mapped tag lookup: registered hit per clock, allocate on miss.
// Optional hit/miss counters are built when CACHE_HIT_STATS_EN is defined.
module cache_main
    import cache_pkg::*;
#(
    parameter int unsigned NUM_LINES   = CACHE_NUM_LINES,
    parameter int unsigned BLOCK_BYTES = CACHE_BLOCK_BYTES,
    parameter int unsigned ADDR_W      = CACHE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instruction,
`ifdef CACHE_HIT_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    output logic              hit
);

    localparam int unsigned INDEX_W  = log2_ceil(NUM_LINES);
    localparam int unsigned OFFSET_W = log2_ceil(BLOCK_BYTES);
    localparam int unsigned TAG_W    = calc_tag_w(ADDR_W, NUM_LINES, BLOCK_BYTES);

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_line_valid;
    logic [TAG_W-1:0]   w_line_tag;
    logic               w_lookup_hit;
    logic               r_hit;

    assign w_index = instruction[OFFSET_W +: INDEX_W];
    assign w_tag   = instruction[ADDR_W-1 -: TAG_W];

    // Offset bits select a byte within the block and play no part in the lookup.
    generate
        if (OFFSET_W > 0) begin : g_offset
            logic w_unused_offset;
            assign w_unused_offset = ^instruction[OFFSET_W-1:0];
        end
    endgenerate

    cache_tag_array #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_tag_array (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_index (w_index),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .i_wr_en    (!w_lookup_hit),
        .i_wr_index (w_index),
        .i_wr_tag   (w_tag)
    );

    assign w_lookup_hit = w_line_valid && (w_line_tag == w_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_lookup_hit;
        end
    end

    assign hit = r_hit;

`ifdef CACHE_HIT_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_lookup_hit) begin
            r_hit_count  <= r_hit_count + 32'd1;
        end else begin
            r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_main.sv
// Directed self-checking bench for cache_main; also checks the counters when CACHE_HIT_STATS_EN is defined.
module tb_cache_main;
    import cache_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        hit;
`ifdef CACHE_HIT_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_cmp;
    int n_fail;

    cache_main dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
`ifdef CACHE_HIT_STATS_EN
        .hit_count   (hit_count),
        .miss_count  (miss_count),
`endif
        .hit         (hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mk_addr(input int unsigned tag, input int unsigned index,
                                            input int unsigned offset);
        addr_fields_t f;
        f.tag    = DEF_TAG_W'(tag);
        f.index  = DEF_INDEX_W'(index);
        f.offset = DEF_OFFSET_W'(offset);
        return f;
    endfunction

    task automatic check_hit(input logic expected, input string tag);
        n_cmp++;
        assert (hit === expected) else begin
            n_fail++;
            $error("FAIL %s: hit observed=%b expected=%b", tag, hit, expected);
        end
    endtask

    // Present one address, let the edge take it, sample 1 ns later.
    task automatic access(input logic [31:0] addr, input logic expected, input string tag);
        instruction = addr;
        @(posedge clk);
        #1;
        check_hit(expected, tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        instruction = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_hit(1'b0, "reset_hit");
        @(negedge clk);
        rst = 1'b0;

        access(32'h0000_0000, 1'b0, "first_after_reset");
        access(32'h0000_0000, 1'b1, "repeat_line0");
        access(32'h0000_000C, 1'b1, "same_block_off12");
        access(32'h0000_0010, 1'b0, "index1_miss");
        access(32'h0000_0010, 1'b1, "index1_hit");

        // Tags 0 and 1 at index 0 keep evicting each other.
        access(mk_addr(1, 0, 0), 1'b0, "conflict_a1");
        access(32'h0000_0000,    1'b0, "conflict_b1");
        access(32'h0000_0400,    1'b0, "conflict_a2");
        access(32'h0000_0000,    1'b0, "conflict_b2");
        access(32'h0000_0400,    1'b0, "conflict_a3");
        access(32'h0000_0000,    1'b0, "conflict_b3");

        do_reset();
        access(32'h0000_03F0, 1'b0, "line63_miss");
        access(32'h0000_03F0, 1'b1, "line63_hit");
        access(32'h0000_0000, 1'b0, "line0_not_aliased");
        access(32'h0000_03FC, 1'b1, "line63_kept");

        access(32'h0000_1230, 1'b0, "alloc_1230");
        access(32'h0000_1230, 1'b1, "hit_1230");
        #2;
        rst = 1'b1;
        #1;
        check_hit(1'b0, "async_reset_clears_hit");
        #2;
        rst = 1'b0;
        access(32'h0000_1230, 1'b0, "miss_after_midreset");
        access(32'h0000_1230, 1'b1, "rehit_after_midreset");

`ifdef CACHE_HIT_STATS_EN
        do_reset();
        access(32'h0000_0000, 1'b0, "stats_0");
        access(32'h0000_0000, 1'b1, "stats_0_r1");
        access(32'h0000_0000, 1'b1, "stats_0_r2");
        access(32'h0000_0000, 1'b1, "stats_0_r3");
        for (int i = 1; i <= 6; i++) begin
            access(mk_addr(0, i, 0), 1'b0, "stats_distinct");
        end
        n_cmp++;
        assert (hit_count === 32'd3) else begin
            n_fail++;
            $error("FAIL hit_count: observed=%0d expected=%0d", hit_count, 3);
        end
        n_cmp++;
        assert (miss_count === 32'd7) else begin
            n_fail++;
            $error("FAIL miss_count: observed=%0d expected=%0d", miss_count, 7);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
